vend_credit_fsm: RTL

Coin-accumulation and vend-control state machine for the vending machine datapath. It accepts coin pulses, tracks credit against a fixed item price, and issues the dispense and change-return handshakes. It sits directly upstream of the per-bit credit-display register bank. It drives that bank's data, load and enable lines: capture on `load`+`En`, high-Z blank on `load` with `!En`.

---
 rtl/vend_credit_fsm.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/vend_credit_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : vend_credit_fsm
//  Description : Coin accumulation and vend control for the vending machine.
//                Tracks credit against a fixed price. Issues the dispense
//                strobe and the change-return handshake. Drives the
//                credit-display register bank: a load with enable captures
//                data, and a load without enable blanks the display.
//  Revision    : 1.0  initial release
// ============================================================================
module vend_credit_fsm #(
    parameter int PRICE    = 15,
    parameter int CREDIT_W = 5
) (
    input  logic                Clk,
    input  logic                Clear_n,
    input  logic                coin5,
    input  logic                coin10,
    input  logic                cancel,
    input  logic                change_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense,
    output logic [CREDIT_W-1:0] change,
    output logic                change_valid,
    output logic                reject,
    output logic [CREDIT_W-1:0] reg_data,
    output logic                reg_load,
    output logic                reg_en
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ACCUM    = 2'd1;
    localparam logic [1:0] S_DISPENSE = 2'd2;
    localparam logic [1:0] S_CHANGE   = 2'd3;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] VAL5_C  = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] VAL10_C = CREDIT_W'(10);

    logic [1:0]          state;
    logic [1:0]          state_nxt;

    logic [CREDIT_W-1:0] credit_nxt;
    logic [CREDIT_W-1:0] change_nxt;
    logic [CREDIT_W-1:0] reg_data_nxt;
    logic                dispense_nxt;
    logic                change_valid_nxt;
    logic                reject_nxt;
    logic                reg_load_nxt;
    logic                reg_en_nxt;

    // A coin counts only when exactly one coin line is high. Both lines high
    // is a refused coin, never a 15-unit deposit.
    logic                coin_valid;
    logic                coin_any;
    logic [CREDIT_W-1:0] coin_value;
    logic [CREDIT_W-1:0] credit_sum;
    logic [CREDIT_W-1:0] overpay;

    assign coin_valid = coin5 ^ coin10;
    assign coin_any   = coin5 | coin10;
    assign coin_value = coin5 ? VAL5_C : VAL10_C;
    assign credit_sum = credit + coin_value;
    assign overpay    = credit - PRICE_C;

    // State and registered outputs; reset clears everything without a blank strobe
    always_ff @(posedge Clk) begin
        if (!Clear_n) begin
            state        <= S_IDLE;
            credit       <= '0;
            change       <= '0;
            reg_data     <= '0;
            dispense     <= 1'b0;
            change_valid <= 1'b0;
            reject       <= 1'b0;
            reg_load     <= 1'b0;
            reg_en       <= 1'b0;
        end else begin
            state        <= state_nxt;
            credit       <= credit_nxt;
            change       <= change_nxt;
            reg_data     <= reg_data_nxt;
            dispense     <= dispense_nxt;
            change_valid <= change_valid_nxt;
            reject       <= reject_nxt;
            reg_load     <= reg_load_nxt;
            reg_en       <= reg_en_nxt;
        end
    end

    // Next-state selection; cancel takes priority over a coin in ACCUM
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (coin_valid) begin
                    state_nxt = (coin_value >= PRICE_C) ? S_DISPENSE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (cancel) begin
                    state_nxt = S_CHANGE;
                end else if (coin_valid && (credit_sum >= PRICE_C)) begin
                    state_nxt = S_DISPENSE;
                end
            end
            S_DISPENSE: begin
                state_nxt = (credit > PRICE_C) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                if (change_ack) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from state and transition
    always_comb begin
        credit_nxt       = credit;
        change_nxt       = change;
        reg_data_nxt     = reg_data;
        reject_nxt       = 1'b0;
        reg_load_nxt     = 1'b0;
        reg_en_nxt       = 1'b0;
        dispense_nxt     = (state_nxt == S_DISPENSE);
        change_valid_nxt = (state_nxt == S_CHANGE);
        case (state)
            S_IDLE: begin
                if (coin_valid) begin
                    credit_nxt   = coin_value;
                    reg_data_nxt = coin_value;
                    reg_load_nxt = 1'b1;
                    reg_en_nxt   = 1'b1;
                end else if (coin_any) begin
                    reject_nxt = 1'b1;
                end
            end
            S_ACCUM: begin
                if (cancel) begin
                    // Refund the whole credit; any coin arriving alongside is refused
                    change_nxt = credit;
                    reject_nxt = coin_any;
                end else if (coin_valid) begin
                    credit_nxt   = credit_sum;
                    reg_data_nxt = credit_sum;
                    reg_load_nxt = 1'b1;
                    reg_en_nxt   = 1'b1;
                end else if (coin_any) begin
                    reject_nxt = 1'b1;
                end
            end
            S_DISPENSE: begin
                reject_nxt = coin_any;
                if (credit > PRICE_C) begin
                    change_nxt = overpay;
                end else begin
                    credit_nxt   = '0;
                    change_nxt   = '0;
                    reg_data_nxt = '0;
                    reg_load_nxt = 1'b1;
                end
            end
            S_CHANGE: begin
                reject_nxt = coin_any;
                if (change_ack) begin
                    credit_nxt   = '0;
                    change_nxt   = '0;
                    reg_data_nxt = '0;
                    reg_load_nxt = 1'b1;
                end
            end
            default: begin
                credit_nxt = '0;
                change_nxt = '0;
            end
        endcase
    end

endmodule
`default_nettype wire
